udma_i2c_cmd_arb: RTL

Transaction-level round-robin arbiter that shares the single uDMA I2C command stream between `N_REQ` command sources, e.g. the uDMA command channel and hardware autonomous sensor-polling engines. Each grant covers one complete I2C transaction, from the first command word through the `last` word, and is held until the I2C core reports completion, NACK, error, or a timeout. The block sits between the requesters and the I2C core's command input. It consumes the core's end-of-transfer, NACK and error pulses and routes a status response back to the owning requester.

---
 rtl/udma_i2c_arb_pkg.sv | 24 ++
 rtl/udma_i2c_rr_arb.sv | 34 +++
 rtl/udma_i2c_cmd_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/udma_i2c_arb_pkg.sv
// rtl/udma_i2c_arb_pkg.sv - shared types for the uDMA I2C command arbiter
package udma_i2c_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_FLUSH,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    STAT_OK   = 2'b00,
    STAT_NACK = 2'b01,
    STAT_ERR  = 2'b10,
    STAT_TMO  = 2'b11
  } arb_status_e;

  // Wraps an index that may overshoot by at most one full lap.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/udma_i2c_rr_arb.sv
// rtl/udma_i2c_rr_arb.sv - round-robin picker: first request at or after ptr_i
module udma_i2c_rr_arb
  import udma_i2c_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int          jj;
    logic [IW-1:0] j;
    jj    = 0;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      jj = rr_wrap(int'(ptr_i) + k, N);
      j  = IW'(jj);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/udma_i2c_cmd_arb.sv
// rtl/udma_i2c_cmd_arb.sv - transaction-level round-robin arbiter for the I2C command stream
module udma_i2c_cmd_arb
  import udma_i2c_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CMD_W = 32,
  parameter int TMO_W = 16
) (
  input  logic                   sys_clk_i,
  input  logic                   rstn_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ-1:0]       req_last_i,
  input  logic [N_REQ*CMD_W-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   cmd_valid_o,
  output logic [CMD_W-1:0]       cmd_data_o,
  input  logic                   cmd_ready_i,
  input  logic                   eot_i,
  input  logic                   nack_i,
  input  logic                   err_i,
  input  logic [TMO_W-1:0]       cfg_timeout_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [1:0]             rsp_status_o,
  output logic                   busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q;
  arb_status_e      status_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    ptr_q;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             own_valid, own_last, hs_last, flush_last, abort;
  logic [CMD_W-1:0] own_data;
  arb_status_e      abort_status;

  udma_i2c_rr_arb #(.N(N_REQ), .IW(IW)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) own_data = own_data | req_data_i[i*CMD_W +: CMD_W];
    end
  end

  assign own_valid    = |(req_valid_i & grant_q);
  assign own_last     = |(req_last_i & grant_q);
  assign hs_last      = (state_q == ARB_STREAM) && own_valid && own_last && cmd_ready_i;
  assign flush_last   = (state_q == ARB_FLUSH) && own_valid && own_last;
  assign abort        = err_i || nack_i;
  assign abort_status = err_i ? STAT_ERR : STAT_NACK;
  // Saturating: counts WAIT cycles including the current one.
  assign cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  assign cmd_valid_o  = (state_q == ARB_STREAM) && own_valid;
  assign cmd_data_o   = (state_q == ARB_STREAM) ? own_data : '0;
  assign grant_o      = grant_q;
  assign rsp_valid_o  = (state_q == ARB_RESP) ? grant_q : '0;
  assign rsp_status_o = (state_q == ARB_RESP) ? status_q : STAT_OK;
  assign busy_o       = (state_q != ARB_IDLE);

  always_comb begin
    req_ready_o = '0;
    case (state_q)
      ARB_STREAM: req_ready_o = grant_q & {N_REQ{cmd_ready_i}};
      ARB_FLUSH:  req_ready_o = grant_q;
      default:    req_ready_o = '0;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      status_q <= STAT_OK;
      grant_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_gnt;
            ptr_q    <= IW'(rr_wrap(int'(pick_idx) + 1, N_REQ));
            status_q <= STAT_OK;
            state_q  <= ARB_STREAM;
          end
        end
        ARB_STREAM: begin
          if (abort) begin
            status_q <= abort_status;
            state_q  <= hs_last ? ARB_RESP : ARB_FLUSH;
          end else if (hs_last) begin
            cnt_q   <= '0;
            state_q <= ARB_WAIT;
          end
        end
        // Status pulses here are ignored so the first recorded status is kept.
        ARB_FLUSH: begin
          if (flush_last) state_q <= ARB_RESP;
        end
        ARB_WAIT: begin
          cnt_q <= cnt_d;
          if (abort) begin
            status_q <= abort_status;
            state_q  <= ARB_RESP;
          end else if (eot_i) begin
            status_q <= STAT_OK;
            state_q  <= ARB_RESP;
          end else if ((cfg_timeout_i != '0) && (cnt_d == cfg_timeout_i)) begin
            status_q <= STAT_TMO;
            state_q  <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          grant_q <= '0;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
